// File: rtl/ser_mem_burst_ctrl_if.sv
// Parallel memory request/response bus between the serial burst controller
// (master) and a word-addressed memory (slave).
interface ser_mem_burst_ctrl_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8
);
   localparam int NB = DATA_W / 8;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [NB-1:0]     mem_be;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/ser_mem_burst_ctrl.sv
// Serial-to-parallel memory burst controller.
// A frame is: address bits, optional burst-length bits, then per word either
// serial write data followed by a memory write, or a memory read followed by
// the word shifted out serially. All outputs are registered.
module ser_mem_burst_ctrl #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8,
   parameter int BLEN_W = 4,
   localparam int NB = DATA_W / 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          cmd_we,
   input  logic [NB-1:0] cmd_be,
   input  logic          burst_en,
   input  logic          ser_in,
   output logic          ser_in_ready,
   output logic          ser_out,
   output logic          ser_out_valid,
   output logic          busy,
   output logic          done,
   output logic          err,
   ser_mem_burst_ctrl_if.master mem
);

   localparam int MAXB  = (DATA_W > ADDR_W) ? ((DATA_W > BLEN_W) ? DATA_W : BLEN_W)
                                            : ((ADDR_W > BLEN_W) ? ADDR_W : BLEN_W);
   localparam int CNT_W = $clog2(MAXB + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_BLEN, S_WDATA, S_MWR, S_MRD, S_RSER, S_FIN
   } state_t;

   state_t            state_q, state_d;
   logic              we_q, we_d;
   logic [NB-1:0]     be_q, be_d;
   logic              burst_q, burst_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [BLEN_W:0]   rem_q, rem_d;      // words left in the frame, including the current one
   logic [CNT_W-1:0]  cnt_q, cnt_d;      // bit position inside the current serial field
   logic [DATA_W-1:0] shift_q, shift_d;

   logic              ready_q, ready_d;
   logic              sout_q, sout_d;
   logic              sval_q, sval_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              req_q, req_d;
   logic              mwe_q, mwe_d;
   logic [ADDR_W-1:0] maddr_q, maddr_d;
   logic [NB-1:0]     mbe_q, mbe_d;
   logic [DATA_W-1:0] mwdata_q, mwdata_d;

   logic [DATA_W-1:0] be_mask;
   logic [BLEN_W:0]   blen_shift;

   // Expand latched byte enables into a bit mask for read data
   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_be_mask
         assign be_mask[gi*8 +: 8] = {8{be_q[gi]}};
      end
   endgenerate

   assign blen_shift = {1'b0, rem_q[BLEN_W-2:0], ser_in};

   // Next-state and next-output computation
   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      be_d    = be_q;
      burst_d = burst_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      err_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               we_d    = cmd_we;
               be_d    = cmd_be;
               burst_d = burst_en;
               addr_d  = '0;
               rem_d   = (BLEN_W+1)'(1);
               cnt_d   = '0;
               shift_d = '0;
               if (cmd_be == '0) begin
                  state_d = S_FIN;
                  err_d   = 1'b1;
               end else begin
                  state_d = S_ADDR;
               end
            end
         end
         S_ADDR: begin
            addr_d = {addr_q[ADDR_W-2:0], ser_in};
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(ADDR_W - 1)) begin
               cnt_d = '0;
               if (burst_q) begin
                  state_d = S_BLEN;
                  rem_d   = '0;
               end else begin
                  state_d = we_q ? S_WDATA : S_MRD;
               end
            end
         end
         S_BLEN: begin
            rem_d = blen_shift;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(BLEN_W - 1)) begin
               // field value N means N+1 words
               rem_d   = blen_shift + (BLEN_W+1)'(1);
               cnt_d   = '0;
               state_d = we_q ? S_WDATA : S_MRD;
            end
         end
         S_WDATA: begin
            shift_d = {shift_q[DATA_W-2:0], ser_in};
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
               cnt_d   = '0;
               state_d = S_MWR;
            end
         end
         S_MWR: begin
            if (mem.mem_ack) begin
               addr_d = addr_q + ADDR_W'(1);
               if (rem_q == (BLEN_W+1)'(1)) begin
                  state_d = S_FIN;
               end else begin
                  rem_d   = rem_q - (BLEN_W+1)'(1);
                  state_d = S_WDATA;
               end
            end
         end
         S_MRD: begin
            if (mem.mem_ack) begin
               shift_d = mem.mem_rdata & be_mask;
               cnt_d   = '0;
               state_d = S_RSER;
            end
         end
         S_RSER: begin
            shift_d = shift_q << 1;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
               cnt_d  = '0;
               addr_d = addr_q + ADDR_W'(1);
               if (rem_q == (BLEN_W+1)'(1)) begin
                  state_d = S_FIN;
               end else begin
                  rem_d   = rem_q - (BLEN_W+1)'(1);
                  state_d = S_MRD;
               end
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs follow the state being entered so they line up with it
      busy_d   = (state_d != S_IDLE);
      ready_d  = (state_d == S_ADDR) || (state_d == S_BLEN) || (state_d == S_WDATA);
      done_d   = (state_d == S_FIN);
      req_d    = (state_d == S_MWR) || (state_d == S_MRD);
      mwe_d    = (state_d == S_MWR);
      maddr_d  = req_d ? addr_d : '0;
      mbe_d    = req_d ? be_d : '0;
      mwdata_d = (state_d == S_MWR) ? shift_d : '0;
      sval_d   = (state_d == S_RSER);
      sout_d   = sval_d & shift_d[DATA_W-1];
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         we_q     <= 1'b0;
         be_q     <= '0;
         burst_q  <= 1'b0;
         addr_q   <= '0;
         rem_q    <= '0;
         cnt_q    <= '0;
         shift_q  <= '0;
         ready_q  <= 1'b0;
         sout_q   <= 1'b0;
         sval_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         req_q    <= 1'b0;
         mwe_q    <= 1'b0;
         maddr_q  <= '0;
         mbe_q    <= '0;
         mwdata_q <= '0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         be_q     <= be_d;
         burst_q  <= burst_d;
         addr_q   <= addr_d;
         rem_q    <= rem_d;
         cnt_q    <= cnt_d;
         shift_q  <= shift_d;
         ready_q  <= ready_d;
         sout_q   <= sout_d;
         sval_q   <= sval_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         req_q    <= req_d;
         mwe_q    <= mwe_d;
         maddr_q  <= maddr_d;
         mbe_q    <= mbe_d;
         mwdata_q <= mwdata_d;
      end
   end

   assign ser_in_ready  = ready_q;
   assign ser_out       = sout_q;
   assign ser_out_valid = sval_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign err           = err_q;
   assign mem.mem_req   = req_q;
   assign mem.mem_we    = mwe_q;
   assign mem.mem_addr  = maddr_q;
   assign mem.mem_be    = mbe_q;
   assign mem.mem_wdata = mwdata_q;

endmodule

// File: tb/tb_ser_mem_burst_ctrl.sv
// Bench for ser_mem_burst_ctrl: directed frames followed by random frames,
// compared against a word-level reference of requests and memory contents.
module tb_ser_mem_burst_ctrl;
   localparam int DW = 16;
   localparam int AW = 8;
   localparam int BW = 4;
   localparam int NB = DW / 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          cmd_we = 1'b0;
   logic [NB-1:0] cmd_be = '0;
   logic          burst_en = 1'b0;
   logic          ser_in = 1'b0;
   logic          ser_in_ready, ser_out, ser_out_valid, busy, done, err;

   ser_mem_burst_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   ser_mem_burst_ctrl #(.DATA_W(DW), .ADDR_W(AW), .BLEN_W(BW)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .cmd_we       (cmd_we),
      .cmd_be       (cmd_be),
      .burst_en     (burst_en),
      .ser_in       (ser_in),
      .ser_in_ready (ser_in_ready),
      .ser_out      (ser_out),
      .ser_out_valid(ser_out_valid),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .mem          (bus)
   );

   typedef struct packed {
      logic          we;
      logic [NB-1:0] be;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } req_t;

   function automatic logic [DW-1:0] init_word(input int a);
      return DW'(a * 40503 + 4660);
   endfunction

   function automatic logic [DW-1:0] lane_mask(input logic [NB-1:0] be);
      logic [DW-1:0] m;
      m = '0;
      for (int l = 0; l < NB; l++) if (be[l]) m[l*8 +: 8] = 8'hFF;
      return m;
   endfunction

   // memory slave: ack after ack_dly waiting cycles (0 = same cycle)
   int            ack_dly = 0;
   int            wait_cnt = 0;
   logic [DW-1:0] mem_arr [256];

   assign bus.mem_ack   = bus.mem_req && (wait_cnt == ack_dly);
   assign bus.mem_rdata = mem_arr[bus.mem_addr];

   always @(posedge clk) begin
      if (bus.mem_req && !bus.mem_ack) wait_cnt <= wait_cnt + 1;
      else                             wait_cnt <= 0;
   end

   // monitor: handshakes, serial output, done/err pulses, request stability
   req_t obs_q[$];
   bit   obs_rx[$];
   int   n_done = 0, n_err = 0, stab_viol = 0, sout_viol = 0;
   bit   mem_init = 1'b0;
   req_t prev_req;
   bit   prev_wait = 1'b0;

   always @(negedge clk) begin
      req_t cur;
      if (!mem_init) begin
         for (int i = 0; i < 256; i++) mem_arr[i] = init_word(i);
         mem_init = 1'b1;
      end
      cur = {bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata};
      if (prev_wait && (!bus.mem_req || cur != prev_req)) stab_viol++;
      prev_wait = bus.mem_req && !bus.mem_ack;
      prev_req  = cur;
      if (bus.mem_req && bus.mem_ack) begin
         obs_q.push_back(cur);
         if (bus.mem_we)
            for (int l = 0; l < NB; l++)
               if (bus.mem_be[l]) mem_arr[bus.mem_addr][l*8 +: 8] = bus.mem_wdata[l*8 +: 8];
      end
      if (ser_out_valid) obs_rx.push_back(ser_out);
      else if (ser_out)  sout_viol++;
      if (done) n_done++;
      if (err)  n_err++;
   end

   // reference state
   logic [DW-1:0] ref_mem [256];
   logic [DW-1:0] dir_data[$];
   logic [DW-1:0] last_rd;
   int            n_chk = 0, n_pass = 0, n_frame = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic run_frame(input bit we, input logic [NB-1:0] be, input bit burst,
                            input logic [AW-1:0] addr, input logic [BW-1:0] blen,
                            input int dly, input int abort_after,
                            input bit chk_lat, input int exp_lat);
      int            nw, k, acks, lat, req_base, rx_base, done_base, err_base;
      bit            bits[$];
      logic [DW-1:0] wd[$];
      logic [DW-1:0] d, got, expw;
      logic [AW-1:0] a;
      bit            got_done, aborted, rst_pend;
      req_t          o;

      nw = (be == '0) ? 0 : (burst ? int'(blen) + 1 : 1);
      for (int i = 0; i < AW; i++) bits.push_back(addr[AW-1-i]);
      if (burst) for (int i = 0; i < BW; i++) bits.push_back(blen[BW-1-i]);
      for (int w = 0; w < nw; w++) begin
         d = (dir_data.size() > 0) ? dir_data.pop_front() : DW'($urandom);
         wd.push_back(d);
         if (we) for (int i = 0; i < DW; i++) bits.push_back(d[DW-1-i]);
      end
      dir_data.delete();
      ack_dly = dly;
      n_frame++;
      $display("frame %0d: %s be=%b burst=%0d addr=0x%02h words=%0d ack_dly=%0d abort_after=%0d",
               n_frame, we ? "WR" : "RD", be, burst, addr, nw, dly, abort_after);

      @(negedge clk); #1;
      req_base = obs_q.size(); rx_base = obs_rx.size();
      done_base = n_done; err_base = n_err;

      @(negedge clk);
      start = 1'b1; cmd_we = we; cmd_be = be; burst_en = burst; ser_in = 1'b0;
      @(negedge clk);
      start = 1'b0;
      k = 1; acks = 0; lat = 0; got_done = 0; aborted = 0; rst_pend = 0;
      while (k < 3000) begin
         if (rst_pend) begin
            rst = 1'b0;
            @(negedge clk);
            check("reset_mid_outputs",
                  {ser_in_ready, ser_out, ser_out_valid, busy, done, err, bus.mem_req}, 0);
            rst = 1'b1;
            aborted = 1;
            break;
         end
         if (bus.mem_req && bus.mem_ack) acks++;
         if (abort_after > 0 && acks == abort_after) rst_pend = 1;
         if (ser_in_ready && bits.size() > 0) ser_in = bits.pop_front();
         else                                 ser_in = 1'b0;
         if (done) begin
            got_done = 1; lat = k;
            break;
         end
         @(negedge clk);
         k++;
      end
      ser_in = 1'b0;

      if (abort_after > 0) begin
         repeat (20) @(negedge clk);
         #1;
         check("abort_reached", aborted, 1);
         check("abort_nreq", obs_q.size() - req_base, abort_after);
         check("abort_no_done", n_done - done_base, 0);
         for (int w = 0; w < abort_after && w < nw; w++) begin
            a = addr + AW'(w);
            if (we) ref_mem[a] = (ref_mem[a] & ~lane_mask(be)) | (wd[w] & lane_mask(be));
         end
         return;
      end

      repeat (3) @(negedge clk);
      #1;
      check("done_seen", got_done, 1);
      if (chk_lat) check("latency", lat, exp_lat);
      check("done_count", n_done - done_base, 1);
      check("err_count", n_err - err_base, (be == '0) ? 1 : 0);
      check("req_count", obs_q.size() - req_base, nw);
      for (int w = 0; w < nw; w++) begin
         a = addr + AW'(w);
         if (req_base + w < obs_q.size()) begin
            o = obs_q[req_base + w];
            check("req_hdr", {o.we, o.be, o.addr}, {we, be, a});
            if (we) check("req_wdata", o.wdata, wd[w]);
         end
         if (we) begin
            ref_mem[a] = (ref_mem[a] & ~lane_mask(be)) | (wd[w] & lane_mask(be));
         end else begin
            expw = ref_mem[a] & lane_mask(be);
            got = '0;
            for (int i = 0; i < DW; i++)
               if (rx_base + w*DW + i < obs_rx.size()) got[DW-1-i] = obs_rx[rx_base + w*DW + i];
            check("read_word", got, expw);
            last_rd = got;
         end
      end
      if (!we) check("rx_bits", obs_rx.size() - rx_base, DW * nw);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NB-1:0] rbe;
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs",
            {ser_in_ready, ser_out, ser_out_valid, busy, done, err,
             bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata}, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // single full-word write, same-cycle ack, latency 26
      dir_data = '{16'hAAAA};
      run_frame(1, 2'b11, 0, 8'h00, 4'd0, 0, 0, 1, 26);
      // lower-byte write
      dir_data = '{16'h1234};
      run_frame(1, 2'b01, 0, 8'h01, 4'd0, 0, 0, 0, 0);
      // burst write wrapping 0xFF -> 0x00 -> 0x01
      dir_data = '{16'hAAAA, 16'hFFFF, 16'h0002};
      run_frame(1, 2'b11, 1, 8'hFF, 4'd2, 1, 0, 0, 0);
      // set up 0x00..0x02 then burst read them back with 3-cycle ack
      dir_data = '{16'hAAAA, 16'hFFFF, 16'h0002};
      run_frame(1, 2'b11, 1, 8'h00, 4'd2, 0, 0, 0, 0);
      run_frame(0, 2'b11, 1, 8'h00, 4'd2, 3, 0, 0, 0);
      check("burst_read_last", last_rd, 16'h0002);
      // upper-lane read masks the low byte
      dir_data = '{16'hABCD};
      run_frame(1, 2'b11, 0, 8'h40, 4'd0, 2, 0, 0, 0);
      run_frame(0, 2'b10, 0, 8'h40, 4'd0, 1, 0, 0, 0);
      check("be10_read", last_rd, 16'hAB00);
      // no lanes enabled: error frame without memory access
      run_frame(0, 2'b00, 0, 8'h40, 4'd0, 0, 0, 0, 0);
      // reset after the second word of a three-word burst, then a normal frame
      dir_data = '{16'h1111, 16'h2222, 16'h3333};
      run_frame(1, 2'b11, 1, 8'h10, 4'd2, 1, 2, 0, 0);
      dir_data = '{16'h5A5A};
      run_frame(1, 2'b11, 0, 8'h12, 4'd0, 0, 0, 1, 26);
      run_frame(0, 2'b11, 1, 8'h10, 4'd2, 0, 0, 0, 0);

      // random frames
      for (int f = 0; f < 25; f++) begin
         rbe = ($urandom_range(0, 7) == 0) ? 2'b00 : NB'($urandom_range(1, 3));
         run_frame($urandom_range(0, 1), rbe, $urandom_range(0, 1), AW'($urandom),
                   BW'($urandom), $urandom_range(0, 3), 0, 0, 0);
      end

      check("req_stable_while_waiting", stab_viol, 0);
      check("ser_out_zero_when_invalid", sout_viol, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/ser_mem_burst_ctrl.md
SER_MEM_BURST_CTRL -- requirements
Module: ser_mem_burst_ctrl

Interface
REQ-001 SHALL have parameters: DATA_W, default 16, word width (multiple of 8); ADDR_W, default 8, word address width; BLEN_W, default 4, burst-length field width; NB = DATA_W/8 byte lanes (derived).
REQ-002 SHALL have one clock; reset is synchronous and active-low.
REQ-003 clk  in  1  sole clock, all state updates on rising edge.
REQ-004 rst  in  1  synchronous active-low reset.
REQ-005 start  in  1  frame-start pulse; command fields sampled on this edge.
REQ-006 cmd_we  in  1  1 = write frame, 0 = read frame.
REQ-007 cmd_be  in  NB  byte-lane enables for the whole frame.
REQ-008 burst_en  in  1  1 = burst-length field follows the address field.
REQ-009 ser_in  in  1  serial address/length/write-data, MSB first.
REQ-010 ser_in_ready  out  1  high on edges where ser_in is sampled.
REQ-011 ser_out  out  1  serial read data, MSB first; 0 when not valid.
REQ-012 ser_out_valid  out  1  qualifies ser_out.
REQ-013 busy  out  1  frame in progress (any state other than IDLE).
REQ-014 done  out  1  one-cycle pulse at frame end.
REQ-015 err  out  1  one-cycle pulse with done on an illegal command.
REQ-016 mem_req, mem_we  out  1 each; mem_addr  out  ADDR_W; mem_be  out  NB; mem_wdata  out  DATA_W: parallel memory request.
REQ-017 mem_rdata  in  DATA_W; mem_ack  in  1: memory response.

Function
REQ-018 States SHALL be IDLE, ADDR, BLEN, WDATA, MWR, MRD, RSER, FIN.
REQ-019 IDLE: start=1 on edge T latches cmd_we, cmd_be, burst_en. Next state is ADDR. If cmd_be=0, next state is FIN with err.
REQ-020 start SHALL be ignored while busy=1.
REQ-021 ADDR: ADDR_W bits sampled on edges T+1..T+ADDR_W, MSB first. Next state is BLEN if burst_en, else WDATA (write) or MRD (read).
REQ-022 BLEN: BLEN_W bits sampled MSB first. Word count = field+1 (1..2^BLEN_W). Without burst_en the count is 1.
REQ-023 ser_in_ready SHALL be 1 exactly in ADDR, BLEN, WDATA; ser_in is ignored elsewhere.
REQ-024 WDATA: DATA_W bits shifted in. On the edge sampling the last bit, the state becomes MWR.
REQ-025 MWR: mem_req=1, mem_we=1, mem_addr=current address, mem_be=latched cmd_be, mem_wdata=shifted word. These are held stable until mem_ack=1 is sampled.
REQ-026 MRD: mem_req=1, mem_we=0, address/be as MWR, until mem_ack. mem_rdata is captured on the ack edge. Bytes with be=0 are forced to 0x00. Next state is RSER.
REQ-027 mem_req SHALL deassert the cycle after the ack edge. mem_ack with mem_req=0 SHALL be ignored.
REQ-028 RSER: DATA_W consecutive cycles with ser_out_valid=1, MSB first, starting the cycle after the ack edge.
REQ-029 After each word, the address SHALL increment modulo 2^ADDR_W (0xFF wraps to 0x00) and the remaining count SHALL decrement. If words remain, the next state is WDATA (write) or MRD (read); otherwise FIN.
REQ-030 FIN: done=1 for one cycle, then IDLE. Minimum single-word write latency start->done = ADDR_W+DATA_W+2 cycles with same-cycle ack.
REQ-031 No timeout: a missing mem_ack holds MWR/MRD indefinitely.

Reset
REQ-032 rst=0 at any edge, including mid-burst, SHALL force IDLE on that edge.
REQ-033 On reset, all outputs SHALL be 0 and the shift, address and count registers SHALL be cleared; the current frame is abandoned without done.

Verification (DATA_W=16, ADDR_W=8, BLEN_W=4)
REQ-034 Single write: cmd_be=11, addr 0x00, data 0xAAAA -> one mem_req, we=1, addr 0x00, be 11, wdata 0xAAAA; done 26 cycles after start with immediate ack.
REQ-035 Lower-byte write: be=01, addr 0x01, data 0x1234 -> mem_be=01, wdata 0x1234, single request.
REQ-036 Burst write: burst_en, addr 0xFF, length field 2, data 0xAAAA, 0xFFFF, 0x0002 -> three requests to 0xFF, 0x00, 0x01 in order; one done.
REQ-037 Burst read: addr 0x00, length 2, memory returns 0xAAAA/0xFFFF/0x0002, ack delayed 3 cycles each -> 48 valid ser_out bits matching the words MSB first; mem_req stable while waiting.
REQ-038 Read with be=10 of stored 0xABCD -> serial word 0xAB00. be=00 -> done+err, no mem_req.
REQ-039 rst=0 mid-burst after the second word -> IDLE next edge, no further mem_req, no done; a new start then completes normally.
